// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the pipelined ALU: the opcode enumeration
//               and the packed status-flag bundle carried beside each result.
// Contents    : alu_op_e    - 3-bit opcode (ADD..SRL)
//               alu_flags_t - {zero, carry, ovf}
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int c_OPCODE_W = 3;

  // The first four codes keep the encoding of the original 2-bit ALU.
  typedef enum logic [c_OPCODE_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    OR  = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    SLT = 3'd5,
    SLL = 3'd6,
    SRL = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational 8-function ALU producing a result and
//               status flags from one operand pair.
// Ports       : func_i   - opcode (alu_op_e)
//               a_i, b_i - operands, WIDTH bits
//               result_o - result, WIDTH bits
//               flags_o  - {zero, carry, ovf}
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e          func_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [SHW-1:0]   w_shamt;
  logic             w_lt;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  // One extra bit on each adder captures the carry out. SUB is a + ~b + 1,
  // so its carry out is 1 exactly when no borrow occurs (a >= b unsigned).
  assign w_add   = {1'b0, a_i} + {1'b0, b_i};
  assign w_sub   = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shamt = b_i[SHW-1:0];
  assign w_lt    = $signed(a_i) < $signed(b_i);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (func_i)
      ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        // Like-signed operands whose sum changes sign.
        w_ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_res[WIDTH-1] != a_i[WIDTH-1]);
      end
      SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        // Unlike-signed operands whose difference takes b's sign.
        w_ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OR:      w_res = a_i | b_i;
      AND:     w_res = a_i & b_i;
      XOR:     w_res = a_i ^ b_i;
      SLT:     w_res = {{(WIDTH-1){1'b0}}, w_lt};
      SLL:     w_res = a_i << w_shamt;
      SRL:     w_res = a_i >> w_shamt;
      default: w_res = '0;
    endcase
  end

  assign result_o      = w_res;
  assign flags_o.zero  = (w_res == '0);
  assign flags_o.carry = w_carry;
  assign flags_o.ovf   = w_ovf;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Pipelined ALU with valid/ready streaming on both sides.
//               Compute happens in front of stage 0; the remaining stages only
//               carry result, flags and valid. Per-stage ready lets bubbles
//               collapse and stalls back-pressure towards the source without
//               dropping or reordering operations.
// Ports       : clock, reset          - clock, synchronous active-high reset
//               in_valid/in_ready     - operand-side handshake
//               in_func, in_a, in_b   - opcode and operands
//               out_valid/out_ready   - result-side handshake
//               out_result            - result
//               out_zero/carry/ovf    - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_func,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf
);

  logic [WIDTH-1:0]                w_core_res;
  alu_flags_t                      w_core_flg;
  logic                            w_in_ready;

  logic [STAGES-1:0]               w_v;
  logic [STAGES-1:0][WIDTH-1:0]    w_res;
  alu_flags_t [STAGES-1:0]         w_flg;
  logic [STAGES:0]                 w_rdy;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .func_i   (alu_op_e'(in_func)),
    .a_i      (in_a),
    .b_i      (in_b),
    .result_o (w_core_res),
    .flags_o  (w_core_flg)
  );

  // A stage can load when it is empty or when its contents move on this
  // cycle; the chain is resolved from the output end backwards.
  always_comb begin
    w_rdy         = '0;
    w_rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_rdy[i] = !w_v[i] || w_rdy[i+1];
    end
  end

  assign w_in_ready = w_rdy[0] && !reset;
  assign in_ready   = w_in_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             v_d;
    logic [WIDTH-1:0] res_d;
    alu_flags_t       flg_d;
    logic             v_q;
    logic [WIDTH-1:0] res_q;
    alu_flags_t       flg_q;

    if (i == 0) begin : g_head
      assign v_d   = in_valid && w_in_ready;
      assign res_d = w_core_res;
      assign flg_d = w_core_flg;
    end else begin : g_body
      assign v_d   = w_v[i-1];
      assign res_d = w_res[i-1];
      assign flg_d = w_flg[i-1];
    end

    // Payload is loaded alongside an empty slot too; it is only meaningful
    // when the valid bit is set, and reset forces it to zero.
    always_ff @(posedge clock) begin
      if (reset) begin
        v_q   <= 1'b0;
        res_q <= '0;
        flg_q <= '0;
      end else if (w_rdy[i]) begin
        v_q   <= v_d;
        res_q <= res_d;
        flg_q <= flg_d;
      end
    end

    assign w_v[i]   = v_q;
    assign w_res[i] = res_q;
    assign w_flg[i] = flg_q;
  end

  assign out_valid  = w_v[STAGES-1];
  assign out_result = w_res[STAGES-1];
  assign out_zero   = w_flg[STAGES-1].zero;
  assign out_carry  = w_flg[STAGES-1].carry;
  assign out_ovf    = w_flg[STAGES-1].ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Scoreboard bench for alu_pipe. Three instances (STAGES = 2, 1
//               and 4) share operands and out_ready; each has its own
//               in_valid. The driver pushes the expected result into a queue
//               on every accept and a monitor pops and compares on retire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int NI = 3;

  typedef struct {
    int         inst;
    logic [W-1:0] res;
    logic [2:0] flg;     // {zero, carry, ovf}
    int         acc;     // edge number of the accept
    bit         lat;     // check latency on retire
    bit         contig;  // must retire the cycle after the previous one
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   func;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_ready;
  logic         iv   [NI];
  logic         ir   [NI];
  logic         ov   [NI];
  logic [W-1:0] ores [NI];
  logic         oz   [NI];
  logic         oc   [NI];
  logic         oo   [NI];

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_ret = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_pipe #(.WIDTH(W), .STAGES(2)) u_s2 (
    .clock(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_func(func),
    .in_a(a), .in_b(b), .out_valid(ov[0]), .out_ready(out_ready), .out_result(ores[0]),
    .out_zero(oz[0]), .out_carry(oc[0]), .out_ovf(oo[0]));

  alu_pipe #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clock(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_func(func),
    .in_a(a), .in_b(b), .out_valid(ov[1]), .out_ready(out_ready), .out_result(ores[1]),
    .out_zero(oz[1]), .out_carry(oc[1]), .out_ovf(oo[1]));

  alu_pipe #(.WIDTH(W), .STAGES(4)) u_s4 (
    .clock(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_func(func),
    .in_a(a), .in_b(b), .out_valid(ov[2]), .out_ready(out_ready), .out_result(ores[2]),
    .out_zero(oz[2]), .out_carry(oc[2]), .out_ovf(oo[2]));

  function automatic int stg(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic clear_valid();
    for (int j = 0; j < NI; j++) iv[j] = 1'b0;
  endtask

  // Present one op to instance k and wait (bounded) until it is accepted.
  task automatic send(input int k, input logic [2:0] f, input logic [W-1:0] va,
                      input logic [W-1:0] vb, input logic [W-1:0] er,
                      input logic [2:0] ef, input bit lat, input bit contig);
    int n;
    @(posedge clk); #1;
    clear_valid();
    iv[k] = 1'b1; func = f; a = va; b = vb;
    #1;
    n = 0;
    while (!ir[k] && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (!ir[k]) begin
      total++; bad++;
      $display("FAIL send_timeout inst=%0d got=in_ready_low want=accept", k);
      iv[k] = 1'b0;
    end else begin
      sb.push_back('{k, er, ef, cyc + 1, lat, contig});
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    clear_valid();
    repeat (n - 1) @(posedge clk);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (!rst && ov[k] && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out inst=%0d got=%h want=none", k, ores[k]);
        end else begin
          e = sb.pop_front();
          if (e.inst != k || ores[k] !== e.res || {oz[k], oc[k], oo[k]} !== e.flg) begin
            bad++;
            $display("FAIL result inst=%0d got=%h flags=%b want inst=%0d %h flags=%b",
                     k, ores[k], {oz[k], oc[k], oo[k]}, e.inst, e.res, e.flg);
          end
          if (e.lat) begin
            total++;
            if (cyc - e.acc + 1 != stg(k)) begin
              bad++;
              $display("FAIL latency inst=%0d got=%0d want=%0d", k, cyc - e.acc + 1, stg(k));
            end
          end
          if (e.contig) begin
            total++;
            if (cyc != last_ret + 1) begin
              bad++;
              $display("FAIL back_to_back inst=%0d got_gap=%0d want_gap=1", k, cyc - last_ret);
            end
          end
        end
        last_ret = cyc;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; out_ready = 1'b1; func = '0; a = '0; b = '0;
    clear_valid();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, ov[0]}, 0);
    chk("rst_out_result", ores[0], 0);
    chk("rst_flags", {29'd0, oz[0], oc[0], oo[0]}, 0);
    chk("rst_in_ready", {31'd0, ir[0]}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, ir[0]}, 1);

    // Single op, latency 2.
    send(0, ADD, 32'd2, 32'd3, 32'd5, 3'b000, 1, 0);
    idle(4);

    // Directed vectors, back to back, no stall.
    send(0, SUB, 32'd2,          32'd3,          32'hFFFF_FFFF, 3'b000, 1, 0);
    send(0, SUB, 32'd5,          32'd5,          32'h0000_0000, 3'b110, 1, 0);
    send(0, ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000, 3'b001, 1, 0);
    send(0, ADD, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 3'b110, 1, 0);
    send(0, ADD, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000, 3'b111, 1, 0);
    send(0, SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 3'b011, 1, 0);
    send(0, SLT, 32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 3'b000, 1, 0);
    send(0, SLT, 32'd1,          32'hFFFF_FFFF,  32'h0000_0000, 3'b100, 1, 0);
    send(0, SLL, 32'd1,          32'd31,         32'h8000_0000, 3'b000, 1, 0);
    send(0, SRL, 32'h8000_0000,  32'd35,         32'h1000_0000, 3'b000, 1, 0);
    send(0, OR,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF, 3'b000, 1, 0);
    send(0, AND, 32'h0000_00F0,  32'h0000_000F,  32'h0000_0000, 3'b100, 1, 0);
    send(0, XOR, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0, 3'b000, 1, 0);
    idle(5);

    // Back-pressure: pipe fills after two accepts, then drains in order.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(0, ADD, 32'd1, 32'd1, 32'd2, 3'b000, 0, 0);
    send(0, ADD, 32'd2, 32'd2, 32'd4, 3'b000, 0, 1);
    @(posedge clk); #1;
    iv[0] = 1'b1; func = ADD; a = 32'd3; b = 32'd3;
    #1;
    chk("bp_in_ready_low", {31'd0, ir[0]}, 0);
    repeat (3) begin
      @(posedge clk); #2;
      chk("bp_hold_in_ready", {31'd0, ir[0]}, 0);
      chk("bp_hold_valid", {31'd0, ov[0]}, 1);
      chk("bp_hold_result", ores[0], 32'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, ir[0]}, 1);
    sb.push_back('{0, 32'd6, 3'b000, cyc + 1, 1'b0, 1'b1});
    send(0, ADD, 32'd4, 32'd4, 32'd8, 3'b000, 0, 1);
    idle(6);

    // Reset with two ops in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    iv[0] = 1'b1; func = ADD; a = 32'd10; b = 32'd10;
    @(posedge clk); #1;
    a = 32'd20; b = 32'd20;
    @(posedge clk); #1;
    clear_valid();
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, ir[0]}, 0);
    @(posedge clk); #1;
    chk("mid_rst_out_valid", {31'd0, ov[0]}, 0);
    chk("mid_rst_out_result", ores[0], 0);
    chk("mid_rst_flags", {29'd0, oz[0], oc[0], oo[0]}, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_release_ready", {31'd0, ir[0]}, 1);
    idle(6);
    send(0, ADD, 32'd2, 32'd3, 32'd5, 3'b000, 1, 0);
    idle(4);

    // Latency with STAGES = 1 and STAGES = 4.
    send(1, ADD, 32'd2, 32'd3, 32'd5, 3'b000, 1, 0);
    idle(4);
    send(2, ADD, 32'd2, 32'd3, 32'd5, 3'b000, 1, 0);
    idle(8);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d_pending want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
